// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: 32-bit big-endian word stream in, FIPS 180-4 padded blocks out (16 words each).
// Optional feature macro SHA_PADDER_BLKCNT_EN adds the blk_cnt output (completed blocks of the current message).
module sha256_msg_padder #(
    parameter int LEN_W = 64
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    input  logic [2:0]       in_nbytes,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_first,
    output logic             out_last,
    output logic [LEN_W-1:0] msg_len,
    output logic             len_start,
    output logic             busy
`ifdef SHA_PADDER_BLKCNT_EN
    ,
    output logic [31:0]      blk_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DATA   = 3'd1,
        S_PAD    = 3'd2,
        S_ZERO   = 3'd3,
        S_LEN_HI = 3'd4,
        S_LEN_LO = 3'd5
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic             run_reg;
    logic             out_valid_reg;
    logic [31:0]      out_data_reg;
    logic             out_last_reg;
    logic [3:0]       wcnt_reg;
    logic [3:0]       gidx_reg;
    logic [LEN_W-1:0] bitcnt_reg;
    logic             len_start_reg;

    logic             load_en;
    logic             accepting;
    logic             in_hs;
    logic             out_hs;
    logic [2:0]       nb_eff;
    logic             short_last;
    logic [31:0]      pad_word;
    logic [LEN_W-1:0] add_bits;
    logic             ld;
    logic [31:0]      ld_data;
    logic             ld_last;

    // gidx_reg is the block index of the next word to be loaded; wcnt_reg tracks the word on the output.
    assign load_en    = ~out_valid_reg | out_ready;
    assign accepting  = run_reg & ((state_reg == S_IDLE) | (state_reg == S_DATA));
    assign in_ready   = accepting & load_en;
    assign in_hs      = in_ready & in_valid;
    assign out_hs     = out_valid_reg & out_ready;
    assign nb_eff     = (in_nbytes > 3'd4) ? 3'd4 : in_nbytes;
    assign short_last = in_last & (nb_eff != 3'd4);
    assign add_bits   = in_last ? LEN_W'({nb_eff, 3'b000}) : LEN_W'(32);

    // Final word: keep valid bytes, 0x80 right after them, zeros beyond.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_pad_byte
            assign pad_word[31-8*gi -: 8] = (3'(gi) < nb_eff)  ? in_data[31-8*gi -: 8] :
                                            (3'(gi) == nb_eff) ? 8'h80 : 8'h00;
        end
    endgenerate

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE, S_DATA: begin
                if (in_hs) begin
                    if (!in_last) begin
                        state_next = S_DATA;
                    end else if (!short_last) begin
                        state_next = S_PAD;
                    end else if (gidx_reg == 4'd13) begin
                        state_next = S_LEN_HI;
                    end else begin
                        state_next = S_ZERO;
                    end
                end
            end
            S_PAD: begin
                if (load_en) begin
                    state_next = (gidx_reg == 4'd13) ? S_LEN_HI : S_ZERO;
                end
            end
            S_ZERO: begin
                // Zero fill runs through index 13, wrapping into a second block when needed.
                if (load_en && (gidx_reg == 4'd13)) begin
                    state_next = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (load_en) begin
                    state_next = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (out_hs && out_last_reg) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        ld      = 1'b0;
        ld_data = 32'h0000_0000;
        ld_last = 1'b0;
        case (state_reg)
            S_IDLE, S_DATA: begin
                ld      = in_hs;
                ld_data = in_last ? pad_word : in_data;
            end
            S_PAD: begin
                ld      = load_en;
                ld_data = 32'h8000_0000;
            end
            S_ZERO: begin
                ld      = load_en;
            end
            S_LEN_HI: begin
                ld      = load_en;
                ld_data = bitcnt_reg[LEN_W-1 -: 32];
            end
            S_LEN_LO: begin
                // Load the low length word once, then only wait for it to drain.
                ld      = load_en & ~out_last_reg;
                ld_data = bitcnt_reg[31:0];
                ld_last = 1'b1;
            end
            default: begin
                ld      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            run_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= 32'h0000_0000;
            out_last_reg  <= 1'b0;
            wcnt_reg      <= 4'd0;
            gidx_reg      <= 4'd0;
            bitcnt_reg    <= '0;
            len_start_reg <= 1'b0;
        end else begin
            run_reg <= 1'b1;
            if (ld) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= ld_data;
                out_last_reg  <= ld_last;
                gidx_reg      <= gidx_reg + 4'd1;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
                out_last_reg  <= 1'b0;
            end
            if (out_hs) begin
                wcnt_reg <= wcnt_reg + 4'd1;
            end
            if (in_hs) begin
                bitcnt_reg <= ((state_reg == S_IDLE) ? '0 : bitcnt_reg) + add_bits;
            end
            len_start_reg <= in_hs & in_last;
        end
    end

`ifdef SHA_PADDER_BLKCNT_EN
    logic [31:0] blk_cnt_reg;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            blk_cnt_reg <= 32'd0;
        end else if (in_hs && (state_reg == S_IDLE)) begin
            blk_cnt_reg <= 32'd0;
        end else if (out_hs && (wcnt_reg == 4'd15)) begin
            blk_cnt_reg <= blk_cnt_reg + 32'd1;
        end
    end

    assign blk_cnt = blk_cnt_reg;
`endif

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_first = out_valid_reg & (wcnt_reg == 4'd0);
    assign out_last  = out_valid_reg & out_last_reg;
    assign msg_len   = bitcnt_reg;
    assign len_start = len_start_reg;
    assign busy      = (state_reg != S_IDLE);

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: directed messages, byte-level padding model feeding a word scoreboard.
`timescale 1ns/1ps
module tb_sha256_msg_padder;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = 32'h0;
    logic        in_last = 1'b0;
    logic [2:0]  in_nbytes = 3'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_first;
    logic        out_last;
    logic [63:0] msg_len;
    logic        len_start;
    logic        busy;
`ifdef SHA_PADDER_BLKCNT_EN
    logic [31:0] blk_cnt;
`endif

    sha256_msg_padder #(.LEN_W(64)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_nbytes (in_nbytes),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_first (out_first),
        .out_last  (out_last),
        .msg_len   (msg_len),
        .len_start (len_start),
        .busy      (busy)
`ifdef SHA_PADDER_BLKCNT_EN
        ,
        .blk_cnt   (blk_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] data;
        logic        first;
        logic        last;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [7:0] msg_q[$];
    int         checks = 0;
    int         errors = 0;
    int         ls_count = 0;
    int         exp_blocks = 0;

    // Output side: every handshake pops one expected word.
    always @(negedge CLK) begin
        if (RST) begin
            if (len_start) ls_count++;
            if (out_valid && out_ready) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL extra_word: got data=%h, expected no word", out_data);
                end
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    checks++;
                    assert ({out_data, out_first, out_last} === mon_e) else begin
                        errors++;
                        $error("FAIL out_word: got data=%h first=%b last=%b, expected data=%h first=%b last=%b",
                               out_data, out_first, out_last, mon_e.data, mon_e.first, mon_e.last);
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference padding done on bytes: append 0x80, zero to 56 mod 64, append 64-bit bit length.
    task automatic build_expected();
        logic [7:0]  p[$];
        logic [63:0] bits;
        exp_t        e;
        int          nw;
        p = msg_q;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        bits = 64'(msg_q.size()) * 64'd8;
        for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
        nw = p.size() / 4;
        for (int w = 0; w < nw; w++) begin
            e.data  = {p[4*w], p[4*w+1], p[4*w+2], p[4*w+3]};
            e.first = ((w % 16) == 0);
            e.last  = (w == nw - 1);
            exp_q.push_back(e);
        end
        exp_blocks = nw / 16;
    endtask

    task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
        int cnt;
        in_data   = d;
        in_last   = last;
        in_nbytes = nb;
        in_valid  = 1'b1;
        cnt = 0;
        @(negedge CLK);
        while (!in_ready && cnt < 200) begin
            @(negedge CLK);
            cnt++;
        end
        chk("in_accept", 64'(in_ready), 64'd1);
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_msg(input logic [7:0] junk, input int stall_after, input bit force_nb);
        int          n;
        int          nw;
        int          nb;
        int          ls0;
        int          cnt;
        logic [31:0] d;
        logic [31:0] held;
        n  = msg_q.size();
        nw = (n == 0) ? 1 : (n + 3) / 4;
        build_expected();
        ls0 = ls_count;
        for (int w = 0; w < nw; w++) begin
            nb = (n - 4*w > 4) ? 4 : n - 4*w;
            for (int b = 0; b < 4; b++) d[31-8*b -: 8] = (b < nb) ? msg_q[4*w+b] : junk;
            if (w == nw - 1) send_word(d, 1'b1, force_nb ? 3'd7 : 3'(nb));
            else             send_word(d, 1'b0, 3'd1);
            if (w == stall_after) begin
                out_ready = 1'b0;
                in_valid  = 1'b1;
                held      = out_data;
                for (int s = 0; s < 5; s++) begin
                    @(negedge CLK);
                    chk("stall_data", {31'd0, out_valid, out_data}, {31'd0, 1'b1, held});
                    chk("stall_in_ready", 64'(in_ready), 64'd0);
                end
                @(posedge CLK);
                #1;
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
        end
        chk("len_start_pulse", 64'(len_start), 64'd1);
        chk("msg_len_at_start", msg_len, 64'(n) * 64'd8);
        cnt = 0;
        while (exp_q.size() != 0 && cnt < 3000) begin
            @(posedge CLK);
            cnt++;
        end
        @(posedge CLK);
        #1;
        chk("drain_left", 64'(exp_q.size()), 64'd0);
        chk("len_start_count", 64'(ls_count - ls0), 64'd1);
        chk("msg_len_hold", msg_len, 64'(n) * 64'd8);
        chk("idle_after", {62'd0, busy, out_valid}, 64'd0);
`ifdef SHA_PADDER_BLKCNT_EN
        chk("blk_cnt", 64'(blk_cnt), 64'(exp_blocks));
`endif
    endtask

    task automatic fill_rand(input int n);
        msg_q.delete();
        for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic load_abc();
        msg_q.delete();
        msg_q.push_back(8'h61);
        msg_q.push_back(8'h62);
        msg_q.push_back(8'h63);
    endtask

    initial begin
        logic [31:0] d;

        repeat (2) @(posedge CLK);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_first", 64'(out_first), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_len_start", 64'(len_start), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_msg_len", msg_len, 64'd0);
        RST = 1'b1;
        #1;
        chk("release_in_ready", 64'(in_ready), 64'd0);
        @(posedge CLK);
        #1;
        chk("first_in_ready", 64'(in_ready), 64'd1);

        // "abc": word 0x61626300, 3 valid bytes.
        load_abc();
        run_msg(8'h00, -1, 1'b0);

        // Empty message.
        msg_q.delete();
        run_msg(8'h5A, -1, 1'b0);

        // Boundary lengths around the 56-byte split.
        fill_rand(56); run_msg(8'hEE, -1, 1'b0);
        fill_rand(55); run_msg(8'hA5, -1, 1'b0);
        fill_rand(59); run_msg(8'h3C, -1, 1'b0);
        fill_rand(60); run_msg(8'hC3, -1, 1'b0);
        fill_rand(61); run_msg(8'h77, -1, 1'b0);

        // in_nbytes above 4 on the last word behaves as 4.
        fill_rand(8); run_msg(8'h11, -1, 1'b1);

        // Backpressure mid-block, then a longer multi-block message.
        fill_rand(20);  run_msg(8'h99, 2, 1'b0);
        fill_rand(130); run_msg(8'h42, -1, 1'b0);

        // Reset in the middle of a message after word 7.
        for (int w = 0; w < 8; w++) begin
            d = $urandom;
            exp_q.push_back('{data: d, first: (w == 0), last: 1'b0});
            send_word(d, 1'b0, 3'd4);
        end
        #1;
        RST = 1'b0;
        #1;
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_out_data", 64'(out_data), 64'd0);
        chk("abort_flags", {60'd0, out_first, out_last, len_start, in_ready}, 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_msg_len", msg_len, 64'd0);
        exp_q.delete();
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        chk("post_abort_ready", {62'd0, in_ready, busy}, 64'd2);
        load_abc();
        run_msg(8'h00, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

endmodule
